control_fsm: RTL and testbench
==============================

# control_fsm

Registered, multi-cycle control unit for the 8-bit single-issue CPU. It decodes the instruction opcode into datapath controls and adds two things the single-cycle decoder cannot do: stall sequencing for the iterative multiplier and a memory handshake using BUSYWAIT. Every control output is registered and fully defined for every opcode. The block sits between the instruction fetch/PC logic and the register file, ALU, operand muxes and data memory.

## Interface
- OPCODE_W, 8: opcode width.
- ALUOP_W, 3: ALU select width.
- MUL_CYCLES, 3: total cycles of a MUL instruction. Legal range is 1 to 15; a value of 1 makes MUL behave as a single-cycle op.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- OPCODE  in  OPCODE_W  opcode of the current instruction. The source holds it stable while STALL=1.
- INSTR_VALID  in  1  OPCODE is valid this cycle.
- BUSYWAIT  in  1  data memory is busy.
- IMM, SIGN  out  1  operand mux selects: immediate, and negate operand 2.
- ALUOP  out  ALUOP_W  ALU function select.
- WRITEENABLE  out  1  register file write strobe.
- J, BEQ, BNEQ  out  1  jump / branch-if-equal / branch-if-not-equal.
- MEMREAD, MEMWRITE  out  1  data memory strobes.
- WB_SEL  out  1  write-back source select: 0 = ALU, 1 = memory.
- STALL  out  1  hold PC and instruction.
- ILLEGAL  out  1  one-cycle pulse on an unknown opcode.

## Operation
- FSM states:
  - DECODE (the reset state).
  - MUL_BUSY.
  - MEM_WAIT.
  - MEM_DONE.
- **Decode table.** Fields are IMM, SIGN, ALUOP, WRITEENABLE. Every output not listed is 0.
  - 0x00 LOADI: 1, 0, 000, 1.
  - 0x01 MOV: 0, 0, 000, 1.
  - 0x02 ADD: 0, 0, 001, 1.
  - 0x03 SUB: 0, 1, 001, 1.
  - 0x04 AND: 0, 0, 010, 1.
  - 0x05 OR: 0, 0, 011, 1.
  - 0x06 J: J=1, WRITEENABLE=0.
  - 0x07 BEQ: SIGN=1, ALUOP=001, BEQ=1.
  - 0x08 BNE: SIGN=1, ALUOP=001, BNEQ=1.
  - 0x09 MUL: ALUOP=100; sequencing described below.
  - 0x0A LWD / 0x0B LWI: ALUOP=000, IMM=1 for LWI only; WB_SEL=1; memory sequencing described below.
  - 0x0C SWD / 0x0D SWI: ALUOP=000, IMM=1 for SWI only; memory sequencing described below.
  - Any other opcode: all controls 0, ILLEGAL=1.
- **DECODE state.**
  - On an edge with INSTR_VALID=1, the controls are loaded into the output registers.
  - MUL with MUL_CYCLES>1 goes to MUL_BUSY. LW/SW go to MEM_WAIT. Every other opcode stays in DECODE.
  - On an edge with INSTR_VALID=0, all outputs become 0.
- **MUL_BUSY state.**
  - A 4-bit counter is loaded with MUL_CYCLES-2 on entry.
  - While in this state: STALL=1, WRITEENABLE=0, ALUOP=100.
  - The counter decrements each edge. On the edge where it equals 0, the FSM returns to DECODE with STALL=0 and WRITEENABLE=1 for one cycle.
- **MEM_WAIT state.**
  - While in this state: MEMREAD=1 (loads) or MEMWRITE=1 (stores), and STALL=1.
  - On an edge with BUSYWAIT=0, the FSM goes to MEM_DONE.
- **MEM_DONE state.**
  - Lasts one cycle: MEMREAD/MEMWRITE=0, STALL=0.
  - Loads: WRITEENABLE=1, WB_SEL=1. Stores: WRITEENABLE=0.
  - The next edge returns to DECODE and accepts INSTR_VALID like DECODE does.
- **While STALL=1:** INSTR_VALID and OPCODE are ignored.

## Timing
- **Reset.** When RESET=1 at an edge:
  - state = DECODE and the counter = 0.
  - Every output is 0 in the following cycle.
  - RESET has priority over all transitions. Asserting it during MUL_BUSY or MEM_WAIT aborts the instruction: no WRITEENABLE and no further MEMREAD/MEMWRITE.
- **Single-cycle ops.**
  - OPCODE sampled at edge n; controls are valid throughout cycle n+1.
  - WRITEENABLE is high for exactly one cycle.
  - A new instruction may be sampled at edge n+1 (back-to-back issue).
- **MUL.**
  - STALL is high for cycles n+1 to n+MUL_CYCLES-1.
  - WRITEENABLE is high in cycle n+MUL_CYCLES only.
  - Total occupancy is MUL_CYCLES cycles.
- **Memory.**
  - Minimum of 2 cycles: MEM_WAIT for 1 cycle, then MEM_DONE for 1 cycle.
  - If BUSYWAIT is high for k consecutive edges, MEM_WAIT lasts k+1 cycles.
  - MEMREAD/MEMWRITE rise and fall on clock edges only, never mid-cycle.
- **ILLEGAL.** Pulses for the one cycle after the edge that sampled the opcode. The FSM stays in DECODE and there is no stall.
- **Glitch-free outputs.** No output may change except at a rising edge. There is no combinational path from any input to any output.

## Test plan
- RESET for 2 cycles, then ADD (0x02) with INSTR_VALID=1 at edge 3 -> all outputs 0 while in reset; cycle 4 shows IMM=0, SIGN=0, ALUOP=001, WRITEENABLE=1, STALL=0.
- Back-to-back LOADI, SUB, BNE, J at consecutive edges -> four consecutive cycles show the table values. BNE shows SIGN=1, BNEQ=1, WRITEENABLE=0. J shows J=1 and everything else 0.
- MUL with MUL_CYCLES=3, plus a second run with MUL_CYCLES=1 -> first run: STALL=1 for 2 cycles, then WRITEENABLE=1 for 1 cycle, ALUOP=100 throughout. Second run: no STALL, WRITEENABLE=1 in the next cycle.
- LWD with BUSYWAIT high for 3 edges, then SWI with BUSYWAIT low immediately ->
  - LWD: MEMREAD=1 and STALL=1 for 4 cycles, then WRITEENABLE=1, WB_SEL=1 for 1 cycle.
  - SWI: MEMWRITE=1 for 1 cycle, IMM=1, WRITEENABLE never asserted.
- RESET asserted in the second cycle of MUL_BUSY, and separately in the second cycle of MEM_WAIT -> the next cycle shows all outputs 0 and state DECODE; no WRITEENABLE pulse ever follows.
- OPCODE 0xFF, then 0x0E -> ILLEGAL=1 for exactly one cycle each; all other outputs 0; no STALL.

Source files
------------

// File: rtl/control_fsm.sv
// Registered multi-cycle control unit for the 8-bit single-issue CPU.
// Decodes the opcode into datapath controls and sequences the iterative
// multiplier and data-memory handshake. All outputs come straight from flops.
module control_fsm #(
  parameter int unsigned OPCODE_W   = 8,
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                INSTR_VALID,
  input  logic                BUSYWAIT,
  output logic                IMM,
  output logic                SIGN,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                WRITEENABLE,
  output logic                J,
  output logic                BEQ,
  output logic                BNEQ,
  output logic                MEMREAD,
  output logic                MEMWRITE,
  output logic                WB_SEL,
  output logic                STALL,
  output logic                ILLEGAL
);

  localparam logic [OPCODE_W-1:0] OpLoadi = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OpMov   = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OpAdd   = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OpSub   = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OpAnd   = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OpOr    = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OpBne   = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OpMul   = OPCODE_W'(8'h09);
  localparam logic [OPCODE_W-1:0] OpLwd   = OPCODE_W'(8'h0A);
  localparam logic [OPCODE_W-1:0] OpLwi   = OPCODE_W'(8'h0B);
  localparam logic [OPCODE_W-1:0] OpSwd   = OPCODE_W'(8'h0C);
  localparam logic [OPCODE_W-1:0] OpSwi   = OPCODE_W'(8'h0D);

  localparam logic [ALUOP_W-1:0] AluPass = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] AluMul  = ALUOP_W'(3'd4);

  // First MUL_BUSY cycle is already counted by the entry edge, hence the -2.
  localparam logic [3:0] MulLoad = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;
  localparam bit         MulMulti = (MUL_CYCLES > 1);

  typedef enum logic [1:0] {
    StDecode,
    StMulBusy,
    StMemWait,
    StMemDone
  } state_e;

  typedef struct packed {
    logic               imm;
    logic               sign;
    logic [ALUOP_W-1:0] aluop;
    logic               we;
    logic               j;
    logic               beq;
    logic               bneq;
    logic               memread;
    logic               memwrite;
    logic               wb_sel;
    logic               stall;
    logic               illegal;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      StMulBusy: begin
        if (cnt_q == 4'd0) begin
          state_d      = StDecode;
          ctrl_d.stall = 1'b0;
          ctrl_d.we    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StMemWait: begin
        if (!BUSYWAIT) begin
          state_d         = StMemDone;
          ctrl_d.memread  = 1'b0;
          ctrl_d.memwrite = 1'b0;
          ctrl_d.stall    = 1'b0;
          // wb_sel is only set for loads, so it doubles as the load flag.
          ctrl_d.we       = ctrl_q.wb_sel;
        end
      end
      StDecode, StMemDone: begin
        state_d = StDecode;
        cnt_d   = 4'd0;
        ctrl_d  = '0;
        if (INSTR_VALID) begin
          case (OPCODE)
            OpLoadi: begin
              ctrl_d.imm = 1'b1;
              ctrl_d.we  = 1'b1;
            end
            OpMov: ctrl_d.we = 1'b1;
            OpAdd: begin
              ctrl_d.aluop = AluAdd;
              ctrl_d.we    = 1'b1;
            end
            OpSub: begin
              ctrl_d.sign  = 1'b1;
              ctrl_d.aluop = AluAdd;
              ctrl_d.we    = 1'b1;
            end
            OpAnd: begin
              ctrl_d.aluop = AluAnd;
              ctrl_d.we    = 1'b1;
            end
            OpOr: begin
              ctrl_d.aluop = AluOr;
              ctrl_d.we    = 1'b1;
            end
            OpJ: ctrl_d.j = 1'b1;
            OpBeq: begin
              ctrl_d.sign  = 1'b1;
              ctrl_d.aluop = AluAdd;
              ctrl_d.beq   = 1'b1;
            end
            OpBne: begin
              ctrl_d.sign  = 1'b1;
              ctrl_d.aluop = AluAdd;
              ctrl_d.bneq  = 1'b1;
            end
            OpMul: begin
              ctrl_d.aluop = AluMul;
              if (MulMulti) begin
                state_d      = StMulBusy;
                cnt_d        = MulLoad;
                ctrl_d.stall = 1'b1;
              end else begin
                ctrl_d.we = 1'b1;
              end
            end
            OpLwd, OpLwi: begin
              state_d        = StMemWait;
              ctrl_d.aluop   = AluPass;
              ctrl_d.imm     = (OPCODE == OpLwi);
              ctrl_d.wb_sel  = 1'b1;
              ctrl_d.memread = 1'b1;
              ctrl_d.stall   = 1'b1;
            end
            OpSwd, OpSwi: begin
              state_d         = StMemWait;
              ctrl_d.aluop    = AluPass;
              ctrl_d.imm      = (OPCODE == OpSwi);
              ctrl_d.memwrite = 1'b1;
              ctrl_d.stall    = 1'b1;
            end
            default: ctrl_d.illegal = 1'b1;
          endcase
        end
      end
      default: begin
        state_d = StDecode;
        cnt_d   = 4'd0;
        ctrl_d  = '0;
      end
    endcase
  end

  // State, counter and output registers; reset wins over every transition.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StDecode;
      cnt_q   <= 4'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IMM         = ctrl_q.imm;
  assign SIGN        = ctrl_q.sign;
  assign ALUOP       = ctrl_q.aluop;
  assign WRITEENABLE = ctrl_q.we;
  assign J           = ctrl_q.j;
  assign BEQ         = ctrl_q.beq;
  assign BNEQ        = ctrl_q.bneq;
  assign MEMREAD     = ctrl_q.memread;
  assign MEMWRITE    = ctrl_q.memwrite;
  assign WB_SEL      = ctrl_q.wb_sel;
  assign STALL       = ctrl_q.stall;
  assign ILLEGAL     = ctrl_q.illegal;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: two instances (MUL_CYCLES=3 and 1) share inputs and
// are each compared every cycle against a cycle-level behavioural model.
module tb_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] OPCODE = 8'h00;
  logic       INSTR_VALID = 1'b0;
  logic       BUSYWAIT = 1'b0;

  always #5 CLK = ~CLK;

  // Output vector: {IMM,SIGN,ALUOP[2:0],WE,J,BEQ,BNEQ,MEMREAD,MEMWRITE,WB_SEL,STALL,ILLEGAL}
  logic [13:0] out_v [2];

  logic       imm0, sign0, we0, j0, beq0, bneq0, mr0, mw0, wb0, st0, il0;
  logic [2:0] alu0;
  logic       imm1, sign1, we1, j1, beq1, bneq1, mr1, mw1, wb1, st1, il1;
  logic [2:0] alu1;

  control_fsm #(.OPCODE_W(8), .ALUOP_W(3), .MUL_CYCLES(3)) dut0 (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
    .IMM(imm0), .SIGN(sign0), .ALUOP(alu0), .WRITEENABLE(we0), .J(j0), .BEQ(beq0),
    .BNEQ(bneq0), .MEMREAD(mr0), .MEMWRITE(mw0), .WB_SEL(wb0), .STALL(st0), .ILLEGAL(il0)
  );

  control_fsm #(.OPCODE_W(8), .ALUOP_W(3), .MUL_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
    .IMM(imm1), .SIGN(sign1), .ALUOP(alu1), .WRITEENABLE(we1), .J(j1), .BEQ(beq1),
    .BNEQ(bneq1), .MEMREAD(mr1), .MEMWRITE(mw1), .WB_SEL(wb1), .STALL(st1), .ILLEGAL(il1)
  );

  assign out_v[0] = {imm0, sign0, alu0, we0, j0, beq0, bneq0, mr0, mw0, wb0, st0, il0};
  assign out_v[1] = {imm1, sign1, alu1, we1, j1, beq1, bneq1, mr1, mw1, wb1, st1, il1};

  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] mk(input logic imm, input logic sign, input logic [2:0] alu,
                                     input logic we, input logic j, input logic beq,
                                     input logic bneq, input logic mr, input logic mw,
                                     input logic wb, input logic st, input logic il);
    return {imm, sign, alu, we, j, beq, bneq, mr, mw, wb, st, il};
  endfunction

  // Single-cycle rows of the decode table; unknown opcodes flag ILLEGAL.
  function automatic logic [13:0] table_vec(input logic [7:0] op);
    case (op)
      8'h00:   return mk(1, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h01:   return mk(0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h02:   return mk(0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h03:   return mk(0, 1, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h04:   return mk(0, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h05:   return mk(0, 0, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      8'h06:   return mk(0, 0, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      8'h07:   return mk(0, 1, 3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      8'h08:   return mk(0, 1, 3'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      default: return mk(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endcase
  endfunction

  function automatic logic [13:0] mem_wait_vec(input logic load, input logic imm);
    return mk(imm, 0, 3'd0, 0, 0, 0, 0, load, !load, load, 1, 0);
  endfunction

  function automatic logic [13:0] mem_done_vec(input logic load, input logic imm);
    return mk(imm, 0, 3'd0, load, 0, 0, 0, 0, 0, load, 0, 0);
  endfunction

  localparam logic [13:0] VMulSt = 14'b0_0_100_0_0_0_0_0_0_0_1_0;
  localparam logic [13:0] VMulWe = 14'b0_0_100_1_0_0_0_0_0_0_0_0;

  // Behavioural model: remaining MUL occupancy cycles and a pending memory op.
  logic [13:0] exp_v [2];
  int          mul_left [2];
  bit          mem_pend [2];
  bit          mem_load [2];
  bit          mem_imm [2];
  bit          started = 0;

  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      int mc;
      mc = (d == 0) ? 3 : 1;
      if (RESET) begin
        exp_v[d]    = '0;
        mul_left[d] = 0;
        mem_pend[d] = 0;
        started     = 1;
      end else if (mul_left[d] > 0) begin
        mul_left[d] = mul_left[d] - 1;
        exp_v[d]    = (mul_left[d] == 0) ? VMulWe : VMulSt;
      end else if (mem_pend[d]) begin
        if (!BUSYWAIT) begin
          mem_pend[d] = 0;
          exp_v[d]    = mem_done_vec(mem_load[d], mem_imm[d]);
        end
      end else if (INSTR_VALID) begin
        if (OPCODE == 8'h09) begin
          mul_left[d] = mc - 1;
          exp_v[d]    = (mc > 1) ? VMulSt : VMulWe;
        end else if (OPCODE >= 8'h0A && OPCODE <= 8'h0D) begin
          mem_load[d] = (OPCODE <= 8'h0B);
          mem_imm[d]  = OPCODE[0];
          mem_pend[d] = 1;
          exp_v[d]    = mem_wait_vec(mem_load[d], mem_imm[d]);
        end else begin
          exp_v[d] = table_vec(OPCODE);
        end
      end else begin
        exp_v[d] = '0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (out_v[d] !== exp_v[d]) begin
          errors++;
          $display("FAIL model dut%0d t=%0t: got %b expected %b", d, $time, out_v[d], exp_v[d]);
        end
      end
    end
  end

  // Drive one cycle of inputs; returns just after the edge that sampled them.
  task automatic cyc(input logic rst, input logic vld, input logic [7:0] op, input logic bw);
    RESET       = rst;
    INSTR_VALID = vld;
    OPCODE      = op;
    BUSYWAIT    = bw;
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input int d, input logic [13:0] want);
    checks++;
    if (out_v[d] !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b", name, d, out_v[d], want);
    end
  endtask

  initial begin
    #2;
    // Reset for two cycles, then ADD.
    cyc(1, 1, 8'h02, 0); lit("reset1", 0, 14'd0);
    cyc(1, 1, 8'h02, 0); lit("reset2", 0, 14'd0); lit("reset2", 1, 14'd0);
    cyc(0, 1, 8'h02, 0); lit("add", 0, 14'b0_0_001_1_0_0_0_0_0_0_0_0);
    // Back-to-back single-cycle ops.
    cyc(0, 1, 8'h00, 0); lit("loadi", 0, 14'b1_0_000_1_0_0_0_0_0_0_0_0);
    cyc(0, 1, 8'h03, 0); lit("sub", 0, 14'b0_1_001_1_0_0_0_0_0_0_0_0);
    cyc(0, 1, 8'h08, 0); lit("bne", 0, 14'b0_1_001_0_0_0_1_0_0_0_0_0);
    cyc(0, 1, 8'h06, 0); lit("j", 0, 14'b0_0_000_0_1_0_0_0_0_0_0_0);
    cyc(0, 0, 8'h06, 0); lit("idle", 0, 14'd0);
    // MUL: three-cycle and single-cycle instances.
    cyc(0, 1, 8'h09, 0); lit("mul_st1", 0, VMulSt); lit("mul1_we", 1, VMulWe);
    cyc(0, 0, 8'h09, 0); lit("mul_st2", 0, VMulSt); lit("mul1_idle", 1, 14'd0);
    cyc(0, 0, 8'h09, 0); lit("mul_we", 0, VMulWe);
    cyc(0, 0, 8'h00, 0); lit("mul_end", 0, 14'd0);
    // LWD with BUSYWAIT high for three MEM_WAIT edges, then SWI.
    cyc(0, 1, 8'h0A, 1); lit("lwd_w1", 0, 14'b0_0_000_0_0_0_0_1_0_1_1_0);
    cyc(0, 0, 8'h00, 1); lit("lwd_w2", 0, 14'b0_0_000_0_0_0_0_1_0_1_1_0);
    cyc(0, 0, 8'h00, 1); lit("lwd_w3", 0, 14'b0_0_000_0_0_0_0_1_0_1_1_0);
    cyc(0, 0, 8'h00, 1); lit("lwd_w4", 0, 14'b0_0_000_0_0_0_0_1_0_1_1_0);
    cyc(0, 0, 8'h00, 0); lit("lwd_done", 0, 14'b0_0_000_1_0_0_0_0_0_1_0_0);
    cyc(0, 1, 8'h0D, 0); lit("swi_w", 0, 14'b1_0_000_0_0_0_0_0_1_0_1_0);
    cyc(0, 0, 8'h00, 0); lit("swi_done", 0, 14'b1_0_000_0_0_0_0_0_0_0_0_0);
    cyc(0, 0, 8'h00, 0); lit("swi_end", 0, 14'd0);
    // Reset aborting MUL_BUSY and MEM_WAIT.
    cyc(0, 1, 8'h09, 0);
    cyc(0, 0, 8'h00, 0); lit("mulabort_pre", 0, VMulSt);
    cyc(1, 0, 8'h00, 0); lit("mulabort_rst", 0, 14'd0);
    cyc(0, 0, 8'h00, 0); lit("mulabort_nowe", 0, 14'd0);
    cyc(0, 1, 8'h0A, 1);
    cyc(0, 0, 8'h00, 1); lit("memabort_pre", 0, 14'b0_0_000_0_0_0_0_1_0_1_1_0);
    cyc(1, 0, 8'h00, 1); lit("memabort_rst", 0, 14'd0);
    cyc(0, 0, 8'h00, 0); lit("memabort_nowe", 0, 14'd0);
    // Illegal opcodes.
    cyc(0, 1, 8'hFF, 0); lit("ill_ff", 0, 14'd1);
    cyc(0, 1, 8'h0E, 0); lit("ill_0e", 0, 14'd1); lit("ill_0e", 1, 14'd1);
    cyc(0, 0, 8'h00, 0); lit("ill_end", 0, 14'd0);
    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] op;
      int         r;
      r  = int'($urandom_range(0, 19));
      op = (r < 16) ? 8'(r) : ((r == 16) ? 8'hFF : 8'($urandom_range(0, 255)));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), op,
          ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
